// File: rtl/act_pkg.sv
// ---------------------------------------------------------------------------
// act_pkg
// Types and helpers shared by the activation stage:
//   act_mode_e  - activation select (ReLU, leaky ReLU, clipped ReLU, identity)
//   act_state_e - pass control states (IDLE, RUN, DONE)
//   sat_hi/lo   - signed saturation bounds for a given output width
// ---------------------------------------------------------------------------
package act_pkg;

   typedef enum logic [1:0] {
      ACT_RELU  = 2'b00,
      ACT_LEAKY = 2'b01,
      ACT_CLIP  = 2'b10,
      ACT_IDENT = 2'b11
   } act_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } act_state_e;

   // Largest value representable in a signed field of 'bits' bits.
   function automatic int sat_hi(input int bits);
      return (1 << (bits - 1)) - 1;
   endfunction

   // Smallest value representable in a signed field of 'bits' bits.
   function automatic int sat_lo(input int bits);
      return -(1 << (bits - 1));
   endfunction

endpackage

// File: rtl/act_lane.sv
// ---------------------------------------------------------------------------
// act_lane
// Combinational per-element activation: rescale by arithmetic right shift,
// apply the selected activation, saturate to OUTBITS.
// Ports:
//   mode  in  2        activation select (act_mode_e encoding)
//   x     in  INBITS   signed input element
//   y     out OUTBITS  signed saturated result
// ---------------------------------------------------------------------------
module act_lane
   import act_pkg::*;
#(
   parameter int INBITS     = 8,
   parameter int OUTBITS    = 8,
   parameter int SHIFT      = 0,
   parameter int LEAK_SHIFT = 3,
   parameter int CLIP       = 6
) (
   input  logic [1:0]         mode,
   input  logic [INBITS-1:0]  x,
   output logic [OUTBITS-1:0] y
);

   localparam int HI       = sat_hi(OUTBITS);
   localparam int LO       = sat_lo(OUTBITS);
   // A ceiling above the output range behaves as the output maximum.
   localparam int CLIP_EFF = (CLIP > HI) ? HI : CLIP;

   localparam logic signed [INBITS-1:0] HI_V   = INBITS'(HI);
   localparam logic signed [INBITS-1:0] LO_V   = INBITS'(LO);
   localparam logic signed [INBITS-1:0] CLIP_V = INBITS'(CLIP_EFF);

   logic signed [INBITS-1:0] s;
   logic signed [INBITS-1:0] a;

   always_comb begin
      // NOTE: every variable gets a default before the case, so no path
      // leaves it unassigned and no latch is inferred.
      s = $signed(x) >>> SHIFT;
      a = s;
      case (act_mode_e'(mode))
         ACT_RELU:  a = (s < 0) ? '0 : s;
         ACT_LEAKY: a = (s < 0) ? (s >>> LEAK_SHIFT) : s;
         ACT_CLIP: begin
            if (s < 0)           a = '0;
            else if (s > CLIP_V) a = CLIP_V;
            else                 a = s;
         end
         default:   a = s;
      endcase

      // Saturate rather than truncate: the narrowing cast is only reached
      // once the value is known to fit.
      if (a > HI_V)      y = OUTBITS'(HI_V);
      else if (a < LO_V) y = OUTBITS'(LO_V);
      else               y = OUTBITS'(a);
   end

endmodule

// File: rtl/activation_unit.sv
// ---------------------------------------------------------------------------
// activation_unit
// Multi-lane activation stage. Processes a SIZE-element signed vector LANES
// elements per cycle into a held, registered output vector.
// Ports:
//   clk      in  1               rising-edge clock
//   reset_n  in  1               asynchronous active-low reset
//   start    in  1               begin a pass (honoured in IDLE or DONE)
//   mode     in  2               activation select, latched on accepted start
//   x        in  SIZE*INBITS     input vector, element i at [i*INBITS +: INBITS]
//   y        out SIZE*OUTBITS    output vector, element i at [i*OUTBITS +: OUTBITS]
//   busy     out 1               high while a pass is running
//   done     out 1               high after a pass until the next accepted start
// ---------------------------------------------------------------------------
module activation_unit
   import act_pkg::*;
#(
   parameter int INBITS     = 8,
   parameter int OUTBITS    = 8,
   parameter int SHIFT      = 0,
   parameter int SIZE       = 10,
   parameter int LANES      = 1,
   parameter int LEAK_SHIFT = 3,
   parameter int CLIP       = 6
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [1:0]                mode,
   input  logic [SIZE*INBITS-1:0]    x,
   output logic [SIZE*OUTBITS-1:0]   y,
   output logic                      busy,
   output logic                      done
);

   localparam int IDXW = $clog2(SIZE + LANES + 1);
   localparam int EW   = (SIZE > 1) ? $clog2(SIZE) : 1;

   act_state_e        state;
   act_mode_e         mode_q;
   logic [IDXW-1:0]   idx;

   logic [INBITS-1:0]  x_el    [SIZE];
   logic [OUTBITS-1:0] y_q     [SIZE];
   logic [INBITS-1:0]  lane_x  [LANES];
   logic [OUTBITS-1:0] lane_y  [LANES];
   logic [EW-1:0]      lane_idx[LANES];
   logic               lane_ok [LANES];

   for (genvar i = 0; i < SIZE; i++) begin : g_el
      assign x_el[i]                    = x[i*INBITS +: INBITS];
      assign y[i*OUTBITS +: OUTBITS]    = y_q[i];
   end

   // Steer elements idx..idx+LANES-1 onto the lanes; lanes past the end of
   // the vector in a partial final group are marked invalid.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_ok[l]  = (int'(idx) + l) < SIZE;
         lane_idx[l] = EW'(int'(idx) + l);
         lane_x[l]   = '0;
         if (lane_ok[l]) lane_x[l] = x_el[lane_idx[l]];
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      act_lane #(
         .INBITS     (INBITS),
         .OUTBITS    (OUTBITS),
         .SHIFT      (SHIFT),
         .LEAK_SHIFT (LEAK_SHIFT),
         .CLIP       (CLIP)
      ) u_lane (
         .mode (mode_q),
         .x    (lane_x[l]),
         .y    (lane_y[l])
      );
   end

   // Control FSM with registered busy/done.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!reset_n) begin
         state  <= ST_IDLE;
         idx    <= '0;
         mode_q <= ACT_RELU;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state  <= ST_RUN;
                  idx    <= '0;
                  mode_q <= act_mode_e'(mode);
                  busy   <= 1'b1;
                  done   <= 1'b0;
               end
            end
            ST_RUN: begin
               // start is deliberately ignored here.
               if (int'(idx) + LANES >= SIZE) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  idx <= idx + IDXW'(LANES);
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Output vector: only the current group is written; everything else holds.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: y_q is a bank of individual flops (each read in parallel), not
      // a RAM, so it can and must be cleared by reset.
      if (!reset_n) begin
         for (int i = 0; i < SIZE; i++) y_q[i] <= '0;
      end else if (state == ST_RUN) begin
         for (int l = 0; l < LANES; l++) begin
            if (lane_ok[l]) y_q[lane_idx[l]] <= lane_y[l];
         end
      end
   end

endmodule
